// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_port_arb_pkg;

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arb_if.sv
// Bundle of both requester ports, both response ports and the memory port.
interface mem_port_arb_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          req0_val;
    logic          req0_rdy;
    logic          req0_type;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          resp0_val;
    logic          resp0_rdy;
    logic [DW-1:0] resp0_rdata;

    logic          req1_val;
    logic          req1_rdy;
    logic          req1_type;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          resp1_val;
    logic          resp1_rdy;
    logic [DW-1:0] resp1_rdata;

    logic          memreq_val;
    logic          memreq_type;
    logic [AW-1:0] memreq_addr;
    logic [DW-1:0] memreq_wdata;
    logic [DW-1:0] memresp_rdata;

    modport slave (
        input  req0_val, req0_type, req0_addr, req0_wdata, resp0_rdy,
        input  req1_val, req1_type, req1_addr, req1_wdata, resp1_rdy,
        input  memresp_rdata,
        output req0_rdy, resp0_val, resp0_rdata,
        output req1_rdy, resp1_val, resp1_rdata,
        output memreq_val, memreq_type, memreq_addr, memreq_wdata
    );

    modport master (
        output req0_val, req0_type, req0_addr, req0_wdata, resp0_rdy,
        output req1_val, req1_type, req1_addr, req1_wdata, resp1_rdy,
        output memresp_rdata,
        input  req0_rdy, resp0_val, resp0_rdata,
        input  req1_rdy, resp1_val, resp1_rdata,
        input  memreq_val, memreq_type, memreq_addr, memreq_wdata
    );

endinterface

// File: rtl/mem_port_arb_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant pointer held here.
module rr_arb2 #(
    parameter bit FIRST_GRANT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_val,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        case (i_val)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Reset value makes FIRST_GRANT win the first contended cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= ~FIRST_GRANT;
        end else if (i_update) begin
            r_last_grant <= o_grant[1];
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one combinational memory port between two val/rdy requesters; one access per 2 cycles.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter bit          FIRST_GRANT = 1'b0,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_port_arb_if.slave io_bus
);

    state_t        r_state;
    state_t        w_state_d;
    logic          r_owner;
    logic [DW-1:0] r_rdata;

    logic [1:0]    w_val;
    logic [1:0]    w_grant;
    logic          w_hs;
    logic          w_win;
    logic          w_type;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_owner_rdy;

    // Requests are only visible in IDLE and outside reset, so no grant leaks otherwise.
    assign w_val = (rst && r_state == IDLE) ? {io_bus.req1_val, io_bus.req0_val} : 2'b00;
    assign w_hs  = |w_grant;
    assign w_win = w_grant[1];

    assign w_type  = w_win ? io_bus.req1_type  : io_bus.req0_type;
    assign w_addr  = w_win ? io_bus.req1_addr  : io_bus.req0_addr;
    assign w_wdata = w_win ? io_bus.req1_wdata : io_bus.req0_wdata;
    assign w_owner_rdy = r_owner ? io_bus.resp1_rdy : io_bus.resp0_rdy;

    rr_arb2 #(
        .FIRST_GRANT (FIRST_GRANT)
    ) u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .i_val    (w_val),
        .i_update (w_hs),
        .o_grant  (w_grant)
    );

    always_comb begin
        w_state_d           = r_state;
        io_bus.req0_rdy     = w_grant[0];
        io_bus.req1_rdy     = w_grant[1];
        io_bus.resp0_val    = 1'b0;
        io_bus.resp1_val    = 1'b0;
        io_bus.resp0_rdata  = '0;
        io_bus.resp1_rdata  = '0;
        io_bus.memreq_val   = 1'b0;
        io_bus.memreq_type  = MEMREQ_READ;
        io_bus.memreq_addr  = '0;
        io_bus.memreq_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    io_bus.memreq_val   = 1'b1;
                    io_bus.memreq_type  = w_type;
                    io_bus.memreq_addr  = w_addr;
                    io_bus.memreq_wdata = w_wdata;
                    w_state_d           = RESP;
                end
            end
            RESP: begin
                if (r_owner) begin
                    io_bus.resp1_val   = 1'b1;
                    io_bus.resp1_rdata = r_rdata;
                end else begin
                    io_bus.resp0_val   = 1'b1;
                    io_bus.resp0_rdata = r_rdata;
                end
                if (w_owner_rdy) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_hs) begin
                r_owner <= w_win;
                r_rdata <= (w_type == MEMREQ_READ) ? io_bus.memresp_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb with a small word-addressed memory model.
module tb_mem_port_arb;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    logic [31:0] mem [0:63];

    mem_port_arb_if #(.AW(32), .DW(32)) bus ();

    mem_port_arb #(
        .FIRST_GRANT (1'b0),
        .AW          (32),
        .DW          (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.memresp_rdata = mem[bus.memreq_addr[7:2]];

    // Memory: word i holds 0xA5A5A5_ii, except word 0x20 (addr 0x80) holds 0x24.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {24'hA5A5A5, 8'(i)};
        mem[32] = 32'h24;
        forever begin
            @(posedge clk);
            if (bus.memreq_val && bus.memreq_type) mem[bus.memreq_addr[7:2]] = bus.memreq_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.req0_val = 1'b1; bus.req0_type = 1'b0; bus.req0_addr = 32'h80; bus.req0_wdata = 0;
        bus.req1_val = 1'b0; bus.req1_type = 1'b0; bus.req1_addr = 0;      bus.req1_wdata = 0;
        bus.resp0_rdy = 1'b0; bus.resp1_rdy = 1'b0;

        // Reset: outputs held at zero even with a request pending
        #2;
        chk("rst_req0_rdy",   32'(bus.req0_rdy),   0);
        chk("rst_memreq_val", 32'(bus.memreq_val), 0);
        chk("rst_memreq_addr", bus.memreq_addr,    0);
        chk("rst_resp0_val",  32'(bus.resp0_val),  0);
        chk("rst_resp0_rdata", bus.resp0_rdata,    0);
        bus.req0_val = 1'b0;
        tick();
        rst = 1'b1;

        // Single read, response held while resp0_rdy low
        bus.req0_val = 1'b1; bus.req0_type = 1'b0; bus.req0_addr = 32'h80;
        #1;
        chk("rd_req0_rdy",    32'(bus.req0_rdy),   1);
        chk("rd_req1_rdy",    32'(bus.req1_rdy),   0);
        chk("rd_memreq_val",  32'(bus.memreq_val), 1);
        chk("rd_memreq_type", 32'(bus.memreq_type), 0);
        chk("rd_memreq_addr", bus.memreq_addr,     32'h80);
        tick();
        bus.req0_val = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rd_resp0_val",   32'(bus.resp0_val),  1);
            chk("rd_resp0_rdata", bus.resp0_rdata,     32'h24);
            chk("rd_resp1_val",   32'(bus.resp1_val),  0);
            chk("rd_resp_memval", 32'(bus.memreq_val), 0);
            tick();
        end
        bus.resp0_rdy = 1'b1;
        tick();
        #1;
        chk("rd_done_resp0_val", 32'(bus.resp0_val), 0);

        // Reset pulse restores last_grant so contention starts with requester 0
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;
        bus.req0_val = 1'b1; bus.req0_type = 1'b0; bus.req0_addr = 32'h00;
        bus.req1_val = 1'b1; bus.req1_type = 1'b0; bus.req1_addr = 32'h04;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_req0_rdy",   32'(bus.req0_rdy), (k % 2 == 0) ? 1 : 0);
            chk("rr_req1_rdy",   32'(bus.req1_rdy), (k % 2 == 1) ? 1 : 0);
            chk("rr_memreq_addr", bus.memreq_addr,  (k % 2 == 0) ? 32'h00 : 32'h04);
            tick();
            #1;
            chk("rr_resp0_val", 32'(bus.resp0_val), (k % 2 == 0) ? 1 : 0);
            chk("rr_resp1_val", 32'(bus.resp1_val), (k % 2 == 1) ? 1 : 0);
            chk("rr_rdata", (k % 2 == 0) ? bus.resp0_rdata : bus.resp1_rdata,
                (k % 2 == 0) ? 32'hA5A5A500 : 32'hA5A5A501);
            chk("rr_resp_rdy_low", 32'({bus.req1_rdy, bus.req0_rdy}), 0);
            tick();
        end
        bus.req0_val = 1'b0; bus.req1_val = 1'b0;

        // Write from req1 then read back from req0
        bus.req1_val = 1'b1; bus.req1_type = 1'b1; bus.req1_addr = 32'h84;
        bus.req1_wdata = 32'hdeadbeef;
        #1;
        chk("wr_req1_rdy",     32'(bus.req1_rdy),    1);
        chk("wr_memreq_type",  32'(bus.memreq_type), 1);
        chk("wr_memreq_wdata", bus.memreq_wdata,     32'hdeadbeef);
        tick();
        bus.req1_val = 1'b0;
        #1;
        chk("wr_resp1_val",   32'(bus.resp1_val), 1);
        chk("wr_resp1_rdata", bus.resp1_rdata,    0);
        tick();
        bus.req0_val = 1'b1; bus.req0_type = 1'b0; bus.req0_addr = 32'h84;
        #1;
        chk("wb_req0_rdy", 32'(bus.req0_rdy), 1);
        tick();
        bus.req0_val = 1'b0;
        #1;
        chk("wb_resp0_val",   32'(bus.resp0_val), 1);
        chk("wb_resp0_rdata", bus.resp0_rdata,    32'hdeadbeef);
        tick();

        // req0 streaming alone: one access every second cycle
        bus.req0_val = 1'b1; bus.req0_type = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.req0_addr = 32'h40 + 32'(4 * k);
            #1;
            chk("bb_req0_rdy", 32'(bus.req0_rdy), 1);
            tick();
            #1;
            chk("bb_resp0_val",   32'(bus.resp0_val), 1);
            chk("bb_resp0_rdata", bus.resp0_rdata,    32'hA5A5A510 + 32'(k));
            chk("bb_busy_rdy",    32'(bus.req0_rdy),  0);
            tick();
        end
        bus.req0_val = 1'b0;

        // Reset while a response is pending discards it
        bus.resp0_rdy = 1'b0;
        bus.req0_val = 1'b1; bus.req0_addr = 32'h80;
        tick();
        bus.req0_val = 1'b0;
        #1;
        chk("rr6_resp0_val_pre", 32'(bus.resp0_val), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("rr6_resp0_val",   32'(bus.resp0_val),  0);
        chk("rr6_resp0_rdata", bus.resp0_rdata,     0);
        chk("rr6_memreq_val",  32'(bus.memreq_val), 0);
        tick();
        chk("rr6_hold_memreq", 32'(bus.memreq_val), 0);
        rst = 1'b1;
        #1;
        chk("rr6_idle_resp0", 32'(bus.resp0_val), 0);
        bus.req0_val = 1'b1;
        #1;
        chk("rr6_idle_rdy", 32'(bus.req0_rdy), 1);
        bus.req0_val = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
